uart_rx_decoder: RTL

- Synthesizable, parametrised UART receiver. It is the next generation of the bench-only baud monitor and is usable both in SoC RTL and as a bench decoder.
- Adds configurable data bits, parity and stop bits.
- Adds majority-vote sampling, glitch rejection, frame/parity/break detection and overrun reporting.
- Buffers received words in a small FIFO behind a valid/ready output.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_rx_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds parity/FSM enums and the oversample divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int uart_div(input int clk_mhz, input int baud, input int os);
    longint num;
    longint den;
    longint d;
    num = longint'(clk_mhz) * 64'd1000000;
    den = longint'(baud) * longint'(os);
    d   = (num + den / 2) / den;
    if (d < 1) d = 1;
    return int'(d);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO; head is shown combinationally from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign count     = r_count;
  assign head      = r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// Oversampling UART receiver with majority-vote bit decisions, parity/frame/break
// detection and a small output FIFO behind a valid/ready interface.
module uart_rx_decoder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_frame_err,
  output logic                          out_parity_err,
  output logic                          overrun,
  output logic                          line_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);
  localparam int DIV = uart_div(CLK_FREQ_MHZ, BAUD_RATE, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int FW  = DATA_BITS + 2;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_S0    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_S1    = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] OS_DEC   = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam bit            HAS_PAR  = (PARITY != int'(PAR_NONE));
  localparam logic          ODD_SENSE = (PARITY == int'(PAR_ODD));

  logic                 r_sync1, r_sync2, r_rx_d;
  logic [1:0]           r_samp;
  logic [DW-1:0]        r_div_cnt;
  logic [OW-1:0]        r_os_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr;
  rx_state_e            r_state, w_next;

  logic                 w_fall, w_start, w_tick, w_dec, w_bit;
  logic                 w_last_stop, w_is_break, w_push, w_perr;
  logic                 w_pop, w_full, w_empty;
  logic [FW-1:0]        w_push_data, w_head;

  // Synchronizer and edge history idle high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_fall  = r_rx_d & ~r_sync2;
  assign w_start = (r_state == IDLE) & w_fall;
  assign w_tick  = (r_div_cnt == DIV_LAST);
  assign w_dec   = w_tick & (r_os_cnt == OS_DEC);
  assign w_bit   = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_sync2) | (r_samp[0] & r_sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
      r_samp    <= 2'b11;
    end else begin
      if (w_start || w_tick) r_div_cnt <= '0;
      else                   r_div_cnt <= r_div_cnt + 1'b1;
      if (w_start)     r_os_cnt <= '0;
      else if (w_tick) r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      if (w_tick && (r_os_cnt == OS_S0 || r_os_cnt == OS_S1)) r_samp <= {r_samp[0], r_sync2};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:             if (w_fall) w_next = START;
      START:            if (w_dec) w_next = w_bit ? IDLE : DATA;
      DATA:             if (w_dec && r_bit_cnt == BIT_LAST) w_next = HAS_PAR ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (w_dec) w_next = STOP;
      STOP: begin
        if (w_is_break)       w_next = BREAK_WAIT;
        else if (w_push)      w_next = IDLE;
      end
      BREAK_WAIT:       if (r_sync2) w_next = IDLE;
      default:          w_next = IDLE;
    endcase
  end

  // A break is recognised on the first stop bit and pushed immediately.
  always_comb begin
    w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
    w_is_break  = 1'b0;
    w_push      = 1'b0;
    if (r_state == STOP && w_dec) begin
      w_is_break = ~r_stop_cnt & ~w_bit & (r_shift == '0) & (~HAS_PAR | ~r_par_bit);
      w_push     = w_last_stop | w_is_break;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_par_bit  <= 1'b0;
        r_ferr     <= 1'b0;
      end
      if (w_dec) begin
        case (r_state)
          DATA: begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          uart_pkg::PARITY: r_par_bit <= w_bit;
          STOP: begin
            r_stop_cnt <= 1'b1;
            r_ferr     <= r_ferr | ~w_bit;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_perr      = HAS_PAR && (((^r_shift) ^ r_par_bit) != ODD_SENSE);
  assign w_push_data = {w_perr, r_ferr | ~w_bit, r_shift};
  assign w_pop       = out_valid & out_ready;

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count),
    .head      (w_head)
  );

  assign out_valid      = ~w_empty;
  assign out_data       = w_head[DATA_BITS-1:0];
  assign out_frame_err  = w_head[DATA_BITS];
  assign out_parity_err = w_head[DATA_BITS+1];
  assign overrun        = w_push & w_full & ~w_pop;
  assign line_break     = w_push & w_is_break;
  assign dbg_state      = r_state;

endmodule
